// File: rtl/cmp_pkg.sv
// Shared definitions for the registered magnitude comparator: outcome encoding
// and the saturating increment used by its event counters.
package cmp_pkg;

   typedef enum logic [1:0] {
      OUT_GT = 2'd0,
      OUT_EQ = 2'd1,
      OUT_LT = 2'd2
   } outcome_t;

   // Holds at max_val instead of wrapping; callers pass their own all-ones limit.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/comp_1bit_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, clears on rst.
module sat_counter
   import cmp_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [CNT_W-1:0] count_nxt;

   assign count_nxt = CNT_W'(sat_inc(32'(count), CNT_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/comp_1bit.sv
// Registered magnitude comparator with one-hot g/e/l flags, a valid flag and
// saturating per-outcome event counters.
module comp_1bit
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             g,
   output logic             e,
   output logic             l,
   output logic             out_valid,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt
);

   // Widen by one bit so a single signed comparator covers both modes.
   logic signed [WIDTH:0] a_ext_p0;
   logic signed [WIDTH:0] b_ext_p0;
   outcome_t              outcome_p0;
   outcome_t              outcome_p1;
   logic                  vld_p1;

   assign a_ext_p0 = (SIGNED != 0) ? $signed({a[WIDTH-1], a}) : $signed({1'b0, a});
   assign b_ext_p0 = (SIGNED != 0) ? $signed({b[WIDTH-1], b}) : $signed({1'b0, b});

   always_comb begin
      outcome_p0 = OUT_EQ;
      if (a_ext_p0 > b_ext_p0) begin
         outcome_p0 = OUT_GT;
      end else if (a_ext_p0 < b_ext_p0) begin
         outcome_p0 = OUT_LT;
      end
   end

   // ---- p0 -> p1 ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= 1'b1;
      end
   end

   // Outcome needs no reset: every flag is qualified by vld_p1.
   always_ff @(posedge clk) begin
      outcome_p1 <= outcome_p0;
   end

   assign g         = vld_p1 && (outcome_p1 == OUT_GT);
   assign e         = vld_p1 && (outcome_p1 == OUT_EQ);
   assign l         = vld_p1 && (outcome_p1 == OUT_LT);
   assign out_valid = vld_p1;

   sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (outcome_p0 == OUT_GT),
      .count (gt_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (outcome_p0 == OUT_EQ),
      .count (eq_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (outcome_p0 == OUT_LT),
      .count (lt_cnt)
   );

endmodule

// File: tb/tb_comp_1bit.sv
// Scoreboard bench for comp_1bit across four parameterisations sharing clk/rst.
module tb_comp_1bit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       a0, b0;
   logic [3:0] a1, b1;
   logic [7:0] a2, b2;
   logic       a3, b3;

   logic        g0, e0, l0, v0;
   logic [15:0] gc0, ec0, lc0;
   logic        g1, e1, l1, v1;
   logic [15:0] gc1, ec1, lc1;
   logic        g2, e2, l2, v2;
   logic [1:0]  gc2, ec2, lc2;
   logic        g3, e3, l3, v3;
   logic [15:0] gc3, ec3, lc3;

   comp_1bit u_dut0 (
      .clk(clk), .rst(rst), .a(a0), .b(b0), .g(g0), .e(e0), .l(l0),
      .out_valid(v0), .gt_cnt(gc0), .eq_cnt(ec0), .lt_cnt(lc0));

   comp_1bit #(.WIDTH(4), .SIGNED(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .g(g1), .e(e1), .l(l1),
      .out_valid(v1), .gt_cnt(gc1), .eq_cnt(ec1), .lt_cnt(lc1));

   comp_1bit #(.WIDTH(8), .SIGNED(0), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .a(a2), .b(b2), .g(g2), .e(e2), .l(l2),
      .out_valid(v2), .gt_cnt(gc2), .eq_cnt(ec2), .lt_cnt(lc2));

   comp_1bit #(.WIDTH(1), .SIGNED(1), .CNT_W(16)) u_dut3 (
      .clk(clk), .rst(rst), .a(a3), .b(b3), .g(g3), .e(e3), .l(l3),
      .out_valid(v3), .gt_cnt(gc3), .eq_cnt(ec3), .lt_cnt(lc3));

   typedef struct packed {
      logic        g, e, l, v;
      logic [31:0] gc, ec, lc;
   } res_t;
   typedef res_t [3:0] exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model configuration and state.
   int wd[4]        = '{1, 4, 8, 1};
   int sg[4]        = '{0, 1, 0, 1};
   int cw[4]        = '{16, 16, 2, 16};
   int mcnt[4][3];

   function automatic longint to_val(int w, int s, logic [63:0] x);
      longint v;
      v = longint'(x & ((64'd1 << w) - 64'd1));
      if (s != 0 && x[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", nm, i, act, expv, $time);
      end
   endtask

   // Advance one edge with the current inputs, then push the model's prediction.
   task automatic cyc(input logic r);
      logic [63:0] ain[4];
      logic [63:0] bin[4];
      exp_t        x;
      longint      av, bv;
      int          k, lim;
      rst = r;
      ain[0] = 64'(a0); bin[0] = 64'(b0);
      ain[1] = 64'(a1); bin[1] = 64'(b1);
      ain[2] = 64'(a2); bin[2] = 64'(b2);
      ain[3] = 64'(a3); bin[3] = 64'(b3);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (r) begin
            for (int j = 0; j < 3; j++) mcnt[i][j] = 0;
            x[i] = '0;
         end else begin
            av = to_val(wd[i], sg[i], ain[i]);
            bv = to_val(wd[i], sg[i], bin[i]);
            k  = (av > bv) ? 0 : ((av == bv) ? 1 : 2);
            lim = (1 << cw[i]) - 1;
            if (mcnt[i][k] < lim) mcnt[i][k]++;
            x[i].g  = (k == 0);
            x[i].e  = (k == 1);
            x[i].l  = (k == 2);
            x[i].v  = 1'b1;
            x[i].gc = 32'(mcnt[i][0]);
            x[i].ec = 32'(mcnt[i][1]);
            x[i].lc = 32'(mcnt[i][2]);
         end
      end
      q.push_back(x);
   endtask

   task automatic set_all(input logic [7:0] va, input logic [7:0] vb);
      a0 = va[0]; b0 = vb[0];
      a1 = va[3:0]; b1 = vb[3:0];
      a2 = va; b2 = vb;
      a3 = va[0]; b3 = vb[0];
   endtask

   // Monitor: outputs are stable at the falling edge.
   always @(negedge clk) begin : monitor
      exp_t x;
      res_t act[4];
      if (q.size() > 0) begin
         x = q.pop_front();
         act[0] = '{g0, e0, l0, v0, 32'(gc0), 32'(ec0), 32'(lc0)};
         act[1] = '{g1, e1, l1, v1, 32'(gc1), 32'(ec1), 32'(lc1)};
         act[2] = '{g2, e2, l2, v2, 32'(gc2), 32'(ec2), 32'(lc2)};
         act[3] = '{g3, e3, l3, v3, 32'(gc3), 32'(ec3), 32'(lc3)};
         for (int i = 0; i < 4; i++) begin
            chk("g", i, 32'(act[i].g), 32'(x[i].g));
            chk("e", i, 32'(act[i].e), 32'(x[i].e));
            chk("l", i, 32'(act[i].l), 32'(x[i].l));
            chk("out_valid", i, 32'(act[i].v), 32'(x[i].v));
            chk("gt_cnt", i, act[i].gc, x[i].gc);
            chk("eq_cnt", i, act[i].ec, x[i].ec);
            chk("lt_cnt", i, act[i].lc, x[i].lc);
            if (x[i].v) begin
               chk("onehot", i, 32'(act[i].g) + 32'(act[i].e) + 32'(act[i].l), 32'd1);
            end
         end
      end
   end

   initial begin
      logic [7:0] ta[4];
      logic [7:0] tb[4];
      logic [3:0] sa[4];
      logic [3:0] sb[4];
      logic       ua[4];
      logic       ub[4];
      ta = '{8'd0, 8'd0, 8'd1, 8'd1};
      tb = '{8'd0, 8'd1, 8'd0, 8'd1};
      sa = '{4'hF, 4'h7, 4'h8, 4'h3};
      sb = '{4'h1, 4'h8, 4'h7, 4'h3};
      ua = '{1'b1, 1'b0, 1'b1, 1'b0};
      ub = '{1'b0, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      set_all(8'd1, 8'd0);
      cyc(1'b1);
      cyc(1'b1);
      chk("rst_valid", 0, 32'(v0), 32'd0);

      // Directed vectors: exhaustive 1-bit, signed 4-bit corners, 1-bit signed.
      for (int s = 0; s < 4; s++) begin
         set_all(ta[s], tb[s]);
         a1 = sa[s]; b1 = sb[s];
         a3 = ua[s]; b3 = ub[s];
         cyc(1'b0);
      end
      chk("dir_gt_cnt", 0, 32'(gc0), 32'd1);
      chk("dir_eq_cnt", 0, 32'(ec0), 32'd2);
      chk("dir_lt_cnt", 0, 32'(lc0), 32'd1);

      // Mid-run reset followed by a held a==b run that saturates the 2-bit counter.
      cyc(1'b1);
      set_all(8'd0, 8'd0);
      cyc(1'b0);
      chk("post_rst_valid", 2, 32'(v2), 32'd1);
      chk("post_rst_eq_cnt", 2, 32'(ec2), 32'd1);
      for (int s = 0; s < 5; s++) cyc(1'b0);
      chk("sat_eq_cnt", 2, 32'(ec2), 32'd3);
      chk("sat_gt_cnt", 2, 32'(gc2), 32'd0);
      chk("sat_lt_cnt", 2, 32'(lc2), 32'd0);

      // Random run.
      for (int s = 0; s < 1000; s++) begin
         set_all(8'($urandom), 8'($urandom));
         if ($urandom_range(0, 7) == 0) b2 = a2;
         if ($urandom_range(0, 7) == 0) b1 = a1;
         cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end

      repeat (3) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
